// File: rtl/io_bus_responder.sv
// Memory-mapped responder for the CPU MEM stage: data RAM with byte/half/word
// access, a peripheral page (7-seg digits, timer, error flags, LEDs, switches).
module io_bus_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned SCAN_DIV  = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_ctrl,
  input  logic [31:0] mem_wd,
  input  logic        mem_we,
  output logic [31:0] mem_rd,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_code,
  output logic [1:0]  err
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [11:0]   OFF_DIG   = 12'h000;
  localparam logic [11:0]   OFF_TIMER = 12'h020;
  localparam logic [11:0]   OFF_ERR   = 12'h024;
  localparam logic [11:0]   OFF_LED   = 12'h060;
  localparam logic [11:0]   OFF_SW    = 12'h070;

  // Active-low {g..a} glyph for one hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_dig, r_timer;
  logic [23:0]   r_led, r_sw_meta, r_sw_sync;
  logic [1:0]    r_err;
  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [7:0]    r_seg_an, r_seg_code;

  logic          w_is_ram, w_is_per, w_word, w_half, w_byte, w_mis;
  logic          w_ram_ok, w_per_ok, w_per_wr;
  logic [1:0]    w_err_set, w_err_clr;
  logic [11:0]   w_off;
  logic [AW-1:0] w_ram_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ram_word, w_rd;
  logic [7:0]    w_lane8;
  logic [15:0]   w_lane16;
  logic          w_unused;

  assign w_off     = mem_addr[11:0];
  assign w_ram_idx = mem_addr[AW+1:2];
  assign w_unused  = mem_ctrl[0];

  // Address decode, alignment and error detection.
  always_comb begin
    w_is_ram  = mem_addr < RAM_BYTES;
    w_is_per  = mem_addr[31:12] == 20'hFFFFF;
    w_half    = mem_ctrl[2:1] == 2'b01;
    w_byte    = mem_ctrl[2:1] == 2'b10;
    w_word    = !w_half && !w_byte;
    w_mis     = (w_half && mem_addr[0]) || (w_word && (mem_addr[1:0] != 2'b00));
    w_ram_ok  = w_is_ram && !w_mis;
    w_per_ok  = w_is_per && w_word && !w_mis;
    w_per_wr  = mem_we && w_per_ok;
    w_err_set = {w_is_per && !w_word, (w_is_ram || (w_is_per && w_word)) && w_mis};
    w_err_clr = (w_per_wr && w_off == OFF_ERR) ? mem_wd[1:0] : 2'b00;
  end

  // Store lane steering: replicate data and enable only the addressed bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_wd;
    if (w_byte) begin
      w_be    = 4'b0001 << mem_addr[1:0];
      w_wdata = {4{mem_wd[7:0]}};
    end else if (w_half) begin
      w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{mem_wd[15:0]}};
    end
    if (!(mem_we && w_ram_ok)) w_be = 4'b0000;
  end

  // RAM is deliberately not reset so a reset cannot disturb its contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_ram[w_ram_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // Zero-latency load path.
  always_comb begin
    w_ram_word = r_ram[w_ram_idx];
    case (mem_addr[1:0])
      2'd0:    w_lane8 = w_ram_word[7:0];
      2'd1:    w_lane8 = w_ram_word[15:8];
      2'd2:    w_lane8 = w_ram_word[23:16];
      default: w_lane8 = w_ram_word[31:24];
    endcase
    w_lane16 = mem_addr[1] ? w_ram_word[31:16] : w_ram_word[15:0];
    w_rd     = '0;
    if (w_ram_ok) begin
      if (w_byte)      w_rd = mem_ctrl[3] ? {24'h0, w_lane8} : {{24{w_lane8[7]}}, w_lane8};
      else if (w_half) w_rd = mem_ctrl[3] ? {16'h0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
      else             w_rd = w_ram_word;
    end else if (w_per_ok) begin
      case (w_off)
        OFF_DIG:   w_rd = r_dig;
        OFF_TIMER: w_rd = r_timer;
        OFF_ERR:   w_rd = {30'h0, r_err};
        OFF_LED:   w_rd = {8'h0, r_led};
        OFF_SW:    w_rd = {8'h0, r_sw_sync};
        default:   w_rd = '0;
      endcase
    end
  end

  // Peripheral registers, switch synchronizer and display scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig      <= '0;
      r_timer    <= '0;
      r_led      <= '0;
      r_err      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_div      <= '0;
      r_idx      <= '0;
      r_seg_an   <= 8'hFE;
      r_seg_code <= 8'hC0;
    end else begin
      if (w_per_wr && w_off == OFF_DIG) r_dig <= mem_wd;
      if (w_per_wr && w_off == OFF_TIMER) r_timer <= mem_wd;
      else                                r_timer <= r_timer + 32'd1;
      if (w_per_wr && w_off == OFF_LED) r_led <= mem_wd[23:0];
      r_err     <= (r_err & ~w_err_clr) | w_err_set;
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
      r_seg_an   <= ~(8'b1 << r_idx);
      r_seg_code <= {1'b1, hex_glyph(r_dig[{r_idx, 2'b00} +: 4])};
    end
  end

  assign mem_rd   = w_rd;
  assign led      = r_led;
  assign err      = r_err;
  assign seg_an   = r_seg_an;
  assign seg_code = r_seg_code;

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Parameters
REQ-001 SHALL have parameter RAM_WORDS, default 1024, data RAM depth in 32-bit words.
REQ-002 SHALL have parameter SCAN_DIV, default 20000, clk cycles each 7-seg digit stays lit.

Interface
REQ-003 SHALL have clk  input  1  system clock, rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have mem_addr  input  32  byte address from CPU MEM stage.
REQ-006 SHALL have mem_ctrl  input  4  {unsigned, size[1:0], we}; size 00 word, 01 half, 10 byte, 11 treated as word; mem_ctrl[0] ignored.
REQ-007 SHALL have mem_wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have mem_we  input  1  store strobe, sole write enable.
REQ-009 SHALL have mem_rd  output  32  load data, extended and right-aligned.
REQ-010 SHALL have sw  input  24  board switches, asynchronous.
REQ-011 SHALL have led  output  24  LED register value.
REQ-012 SHALL have seg_an  output  8  digit enables, active-low one-hot.
REQ-013 SHALL have seg_code  output  8  segments {dp,g..a}, active-low; dp always 1.
REQ-014 SHALL have err  output  2  sticky error flags (ERR register bits [1:0]).

Function
REQ-015 Decode: RAM when mem_addr < 4*RAM_WORDS; peripheral page when mem_addr[31:12]=0xFFFFF; else unmapped.
REQ-016 mem_rd SHALL be combinational from current mem_addr/mem_ctrl (zero-cycle read latency); CPU samples it same cycle.
REQ-017 Writes SHALL commit at rising clk when mem_we=1; new value visible on mem_rd the following cycle.
REQ-018 RAM byte load: lane mem_addr[1:0]; half load: lane mem_addr[1]; sign-extend when unsigned=0, zero-extend when unsigned=1.
REQ-019 RAM byte store updates only selected byte; half store only selected 16 bits; other bytes unchanged.
REQ-020 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): store dropped, load returns 0, err[0] set on the clock edge (loads and stores).
REQ-021 Peripheral map (word access only): 0x000 DIG RW 32b, 0x020 TIMER RW, 0x024 ERR (read {30'b0,err}, write-1-to-clear), 0x060 LED RW [23:0], 0x070 SW RO [23:0]; other offsets read 0, writes ignored.
REQ-022 Non-word access to peripheral page: store dropped, load returns 0, err[1] set.
REQ-023 Unmapped: loads return 0, stores ignored, no error flag.
REQ-024 sw SHALL pass a 2-flop synchronizer; SW reads return synchronized value (2-cycle latency).
REQ-025 TIMER increments by 1 every cycle, wraps 0xFFFFFFFF->0; CPU write loads mem_wd, write wins over increment, counting resumes next cycle.
REQ-026 ERR write-1-to-clear and a same-cycle new error on same bit: set wins.
REQ-027 Scan: divider counts 0..SCAN_DIV-1; at terminal count digit index advances 0..7, wraps 7->0.
REQ-028 Digit i SHALL light seg_an[i]=0 and show hex glyph of DIG[4i+3:4i] (0-F, standard 7-seg); outputs registered, change one cycle after index changes.

Reset
REQ-029 On rst_n=0 immediately: DIG, TIMER, LED, err, divider, digit index, synchronizer = 0; seg_an=8'hFE, seg_code = glyph '0' (8'hC0).
REQ-030 RAM contents SHALL NOT be reset; a reset mid-write SHALL not corrupt unaddressed words.
REQ-031 After rst_n release, first write accepted at first rising clk.

Verification
REQ-032 Store word 0x8899AABB to 0x10, lb 0x11 unsigned=0 -> mem_rd 0xFFFFFFAA; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899.
REQ-033 sb 0x5C to 0x12 over 0x8899AABB -> lw 0x10 returns 0x885CAABB; sh 0x1234 to 0x11 -> dropped, err=2'b01, ERR write 1 -> err=0.
REQ-034 Write TIMER=0xFFFFFFFE, read next two cycles -> 0xFFFFFFFE, 0xFFFFFFFF, then 0x00000000.
REQ-035 sw=0x00A5A5, read SW 1 cycle later -> 0 (not yet), 2+ cycles later -> 0x00A5A5; write LED 0x123456 -> led=0x123456; lb from LED -> 0, err[1]=1.
REQ-036 SCAN_DIV=4, DIG=0x89ABCDEF -> digit 0 shows F (8'h8E) with seg_an=8'hFE, advances every 4 cycles, after digit 7 (8, 8'h80, seg_an=8'h7F) wraps to digit 0; rst_n pulse mid-scan -> seg_an=8'hFE immediately.
